// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the loader state encoding, the default NOP word and the count sizing helper.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    // count must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Simple 1W1R synchronous RAM with a registered read port.
// Holds only the array; callers decide when a read is meaningful.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // write port and registered read; rdata holds when no read is issued
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory for the fetch stage.
// Words stream in over valid/ready; fetches are byte-addressed with 1-cycle latency.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              fault,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    state_t            state;
    logic [AW-1:0]     wptr;
    logic [CW-1:0]     count;
    logic              show_nop;
    logic [DATA_W-1:0] rdata;

    logic              handshake;
    logic              fetch_srv;
    logic              fetch_ok;
    logic [ADDR_W-1:0] idx_full;
    logic [ADDR_W-1:0] count_ext;

    assign handshake = (state == LOAD) && load_valid && load_ready;

    // full-width index compare so high PCs can never alias into the array
    assign idx_full  = {2'b00, pc[ADDR_W-1:2]};
    assign count_ext = ADDR_W'(count);
    assign fetch_ok  = (state == READY) && (pc[1:0] == 2'b00)
                     && (idx_full < count_ext);

    // fetches are answered in EMPTY and READY, silently dropped in LOAD
    assign fetch_srv = fetch_req && (state != LOAD);

    // rdata only moves on good fetches, so the mux output holds between them
    assign instruction = show_nop ? NOP_WORD : rdata;

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (handshake),
        .waddr (wptr),
        .wdata (load_data),
        .re    (fetch_srv && fetch_ok),
        .raddr (pc[AW+1:2]),
        .rdata (rdata)
    );

    // loader state machine plus registered fetch response flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            wptr        <= '0;
            count       <= '0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            show_nop    <= 1'b1;
        end else begin
            load_done   <= 1'b0;
            instr_valid <= fetch_srv;
            if (fetch_srv) begin
                fault    <= !fetch_ok;
                show_nop <= !fetch_ok;
            end
            unique case (state)
                EMPTY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        count      <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        wptr  <= wptr + AW'(1);
                        count <= count + CW'(1);
                        if (load_last || (wptr == AW'(DEPTH - 1))) begin
                            state      <= READY;
                            load_ready <= 1'b0;
                            busy       <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        count      <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule
